pi1_bram_ctrl: RTL and testbench



---
 rtl/pi1_bram_ctrl_pkg.sv | 28 ++
 rtl/pi1_bram_ctrl_if.sv | 20 ++
 rtl/pi1_bram_ctrl.sv | 123 ++++++++++++
 tb/tb_pi1_bram_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pi1_bram_ctrl_pkg.sv
// Shared PI1 op codes, controller state type and the width-generic byte merge
// used for partial writes and swaps on BRAM port 1.
package pi1_bram_ctrl_pkg;

  localparam logic [1:0] PI1_OPNOTREADY = 2'd0;
  localparam logic [1:0] PI1_OPRDWR     = 2'd1;
  localparam logic [1:0] PI1_OPWRITE    = 2'd2;
  localparam logic [1:0] PI1_OPREAD     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_RMW  = 2'd2
  } state_e;

  // Operates at the widest legal data width (64); callers zero-extend and truncate.
  function automatic logic [63:0] byte_merge(input logic [63:0] old_w,
                                             input logic [63:0] new_w,
                                             input logic [7:0]  sel);
    logic [63:0] res;
    res = old_w;
    for (int b = 0; b < 8; b++) begin
      if (sel[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pi1_bram_ctrl_if.sv
// PI1 slave-side bus bundle: request (op/addr/data/sel) from the master,
// registered read data and ready back from the slave.
interface pi1_bram_ctrl_if #(
  parameter int ARCHBITSZ = 32,
  parameter int SZ        = 1024
);
  localparam int ADDRBITSZ = $clog2(SZ);

  logic [1:0]             pi1_op_i;
  logic [ADDRBITSZ-1:0]   pi1_addr_i;
  logic [ARCHBITSZ-1:0]   pi1_data_i;
  logic [ARCHBITSZ/8-1:0] pi1_sel_i;
  logic [ARCHBITSZ-1:0]   pi1_data_o;
  logic                   pi1_rdy_o;

  modport master (output pi1_op_i, pi1_addr_i, pi1_data_i, pi1_sel_i,
                  input  pi1_data_o, pi1_rdy_o);
  modport slave  (input  pi1_op_i, pi1_addr_i, pi1_data_i, pi1_sel_i,
                  output pi1_data_o, pi1_rdy_o);
endinterface

// File: rtl/pi1_bram_ctrl.sv
// PI1 slave on BRAM port 1: reads (1 wait), full writes (0 wait), partial writes via RMW (1 wait).
// Optional PI1_BRAM_CTRL_RDWR_EN makes RDWR an atomic swap through the RMW path; otherwise RDWR reads.
module pi1_bram_ctrl
  import pi1_bram_ctrl_pkg::*;
#(
  parameter int ARCHBITSZ = 32,
  parameter int SZ        = 1024,
  localparam int ADDRBITSZ = $clog2(SZ)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  pi1_bram_ctrl_if.slave       pi1,
  output logic                 bram_en_o,
  output logic                 bram_we_o,
  output logic [ADDRBITSZ-1:0] bram_addr_o,
  output logic [ARCHBITSZ-1:0] bram_data_o,
  input  logic [ARCHBITSZ-1:0] bram_data_i
);

  localparam int NSEL = ARCHBITSZ / 8;

  state_e               state_q, state_d;
  logic                 rdy_q, rdy_d;
  logic                 swap_q, swap_d;
  logic [ARCHBITSZ-1:0] dout_q, dout_d;
  logic [ARCHBITSZ-1:0] wdata_q, wdata_d;
  logic [ADDRBITSZ-1:0] addr_q, addr_d;
  logic [NSEL-1:0]      sel_q, sel_d;
  logic                 en_c, we_c;
  logic                 rd_op, swap_op, wr_op;

`ifdef PI1_BRAM_CTRL_RDWR_EN
  assign rd_op   = (pi1.pi1_op_i == PI1_OPREAD);
  assign swap_op = (pi1.pi1_op_i == PI1_OPRDWR);
`else
  assign rd_op   = (pi1.pi1_op_i == PI1_OPREAD) || (pi1.pi1_op_i == PI1_OPRDWR);
  assign swap_op = 1'b0;
`endif
  assign wr_op = (pi1.pi1_op_i == PI1_OPWRITE);

  always_comb begin
    state_d     = state_q;
    rdy_d       = rdy_q;
    swap_d      = swap_q;
    dout_d      = dout_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    sel_d       = sel_q;
    en_c        = 1'b0;
    we_c        = 1'b0;
    bram_addr_o = pi1.pi1_addr_i;
    bram_data_o = pi1.pi1_data_i;
    case (state_q)
      ST_IDLE: begin
        if (rdy_q && pi1.pi1_op_i != PI1_OPNOTREADY) begin
          if (rd_op) begin
            en_c    = 1'b1;
            rdy_d   = 1'b0;
            state_d = ST_RD;
          end else if (wr_op && (&pi1.pi1_sel_i)) begin
            en_c = 1'b1;
            we_c = 1'b1;
          end else if (swap_op || (wr_op && (|pi1.pi1_sel_i))) begin
            // Read the old word now; the merged write lands next cycle.
            en_c    = 1'b1;
            addr_d  = pi1.pi1_addr_i;
            wdata_d = pi1.pi1_data_i;
            sel_d   = pi1.pi1_sel_i;
            swap_d  = swap_op;
            rdy_d   = 1'b0;
            state_d = ST_RMW;
          end
        end
      end
      ST_RD: begin
        dout_d  = bram_data_i;
        rdy_d   = 1'b1;
        state_d = ST_IDLE;
      end
      ST_RMW: begin
        en_c        = 1'b1;
        we_c        = 1'b1;
        bram_addr_o = addr_q;
        bram_data_o = ARCHBITSZ'(byte_merge(64'(bram_data_i), 64'(wdata_q), 8'(sel_q)));
        if (swap_q) dout_d = bram_data_i;
        rdy_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        rdy_d   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Gating with reset also drops the pending RMW write if reset lands mid-operation.
  assign bram_en_o = en_c & ~rst_i;
  assign bram_we_o = we_c & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b1;
      swap_q  <= 1'b0;
      dout_q  <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      swap_q  <= swap_d;
      dout_q  <= dout_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
    end
  end

  assign pi1.pi1_rdy_o  = rdy_q;
  assign pi1.pi1_data_o = dout_q;

endmodule

// File: tb/tb_pi1_bram_ctrl.sv
// Bench for pi1_bram_ctrl: behavioural BRAM on port 1, directed scenarios, then
// random ops against an array-based reference of memory contents and bus timing.
module tb_pi1_bram_ctrl;
  import pi1_bram_ctrl_pkg::*;

  localparam int ARCHBITSZ = 32;
  localparam int SZ        = 1024;
  localparam int AW        = $clog2(SZ);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pi1_bram_ctrl_if #(.ARCHBITSZ(ARCHBITSZ), .SZ(SZ)) pi1();

  logic          bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_wdat, bram_q;

  pi1_bram_ctrl #(.ARCHBITSZ(ARCHBITSZ), .SZ(SZ)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .pi1        (pi1),
    .bram_en_o  (bram_en),
    .bram_we_o  (bram_we),
    .bram_addr_o(bram_addr),
    .bram_data_o(bram_wdat),
    .bram_data_i(bram_q)
  );

  // Registered read-before-write BRAM, with a backdoor preload port.
  logic [31:0]   mem [SZ];
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [31:0]   poke_dat = '0;
  int            wr_cnt = 0;

  always @(posedge clk) begin
    if (poke_en) begin
      mem[poke_addr] <= poke_dat;
    end else if (bram_en) begin
      bram_q <= mem[bram_addr];
      if (bram_we) mem[bram_addr] <= bram_wdat;
    end
    if (bram_en && bram_we) wr_cnt <= wr_cnt + 1;
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] ref_mem [SZ];
  logic [31:0] exp_dout = '0;
  logic        en_at_accept;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    poke_en = 1'b1; poke_addr = AW'(a); poke_dat = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
    ref_mem[a] = d;
  endtask

  function automatic logic [31:0] merge_ref(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  // Reference: expected wait cycles, port enable at accept, read data, memory update.
  task automatic model(input logic [1:0] op, input int a, input logic [31:0] d,
                       input logic [3:0] s, output int lat, output logic en);
    logic [31:0] old;
    old = ref_mem[a];
    lat = 0;
    en  = 1'b1;
    if (op == PI1_OPREAD) begin
      lat = 1; exp_dout = old;
    end else if (op == PI1_OPRDWR) begin
      lat = 1; exp_dout = old;
`ifdef PI1_BRAM_CTRL_RDWR_EN
      ref_mem[a] = merge_ref(old, d, s);
`endif
    end else if (op == PI1_OPWRITE) begin
      if (s == 4'hF) ref_mem[a] = d;
      else if (s == 4'h0) en = 1'b0;
      else begin lat = 1; ref_mem[a] = merge_ref(old, d, s); end
    end
  endtask

  task automatic bus_op(input logic [1:0] op, input int a, input logic [31:0] d,
                        input logic [3:0] s, output int lat);
    pi1.pi1_op_i = op; pi1.pi1_addr_i = AW'(a); pi1.pi1_data_i = d; pi1.pi1_sel_i = s;
    @(negedge clk);
    en_at_accept = bram_en;
    @(posedge clk); #1;
    pi1.pi1_op_i = PI1_OPNOTREADY;
    lat = 0;
    while (pi1.pi1_rdy_o !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_check(input string tag, input logic [1:0] op, input int a,
                           input logic [31:0] d, input logic [3:0] s);
    int lat, exp_lat;
    logic exp_en;
    model(op, a, d, s, exp_lat, exp_en);
    bus_op(op, a, d, s, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_en"}, 64'(en_at_accept), 64'(exp_en));
    chk({tag, "_dout"}, 64'(pi1.pi1_data_o), 64'(exp_dout));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int pre;
    int lat;
    pi1.pi1_op_i = PI1_OPREAD; pi1.pi1_addr_i = AW'(5);
    pi1.pi1_data_i = '0; pi1.pi1_sel_i = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_en", 64'(bram_en), 64'(0));
    chk("reset_we", 64'(bram_we), 64'(0));
    chk("reset_rdy", 64'(pi1.pi1_rdy_o), 64'(1));
    chk("reset_dout", 64'(pi1.pi1_data_o), 64'(0));
    pi1.pi1_op_i = PI1_OPNOTREADY;
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) poke(i, $urandom);
    poke(SZ-1, $urandom);
    poke(5, 32'hDEADBEEF);
    poke(9, 32'hAABBCCDD);
    poke(3, 32'h0);
    poke(2, 32'h55555555);
    poke(4, 32'hCAFEF00D);

    run_check("read5", PI1_OPREAD, 5, 32'h0, 4'h0);
    chk("read5_const", 64'(pi1.pi1_data_o), 64'h00000000DEADBEEF);

    run_check("wrfull7", PI1_OPWRITE, 7, 32'h12345678, 4'hF);
    run_check("rd7", PI1_OPREAD, 7, 32'h0, 4'h0);
    chk("rd7_const", 64'(pi1.pi1_data_o), 64'h0000000012345678);

    run_check("wrpart9", PI1_OPWRITE, 9, 32'h11223344, 4'b0101);
    run_check("rd9", PI1_OPREAD, 9, 32'h0, 4'h0);
    chk("rd9_const", 64'(pi1.pi1_data_o), 64'h00000000AA22CC44);

    // Partial write to addr 3, reset lands in its RMW cycle.
    pi1.pi1_op_i = PI1_OPWRITE; pi1.pi1_addr_i = AW'(3);
    pi1.pi1_data_i = 32'hFFFFFFFF; pi1.pi1_sel_i = 4'b0011;
    @(posedge clk); #1;
    pi1.pi1_op_i = PI1_OPNOTREADY;
    rst = 1'b1;
    pre = wr_cnt;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_rmw_nowrite", 64'(wr_cnt), 64'(pre));
    chk("rst_rmw_rdy", 64'(pi1.pi1_rdy_o), 64'(1));
    chk("rst_rmw_dout", 64'(pi1.pi1_data_o), 64'(0));
    exp_dout = '0;
    run_check("rd3", PI1_OPREAD, 3, 32'h0, 4'h0);
    chk("rd3_const", 64'(pi1.pi1_data_o), 64'(0));

    run_check("rdwr2", PI1_OPRDWR, 2, 32'hFFFFFFFF, 4'hF);
    chk("rdwr2_old", 64'(pi1.pi1_data_o), 64'h0000000055555555);
    run_check("rd2", PI1_OPREAD, 2, 32'h0, 4'h0);
`ifdef PI1_BRAM_CTRL_RDWR_EN
    chk("rd2_const", 64'(pi1.pi1_data_o), 64'h00000000FFFFFFFF);
`else
    chk("rd2_const", 64'(pi1.pi1_data_o), 64'h0000000055555555);
`endif

    pre = wr_cnt;
    run_check("wrsel0_4", PI1_OPWRITE, 4, 32'h01234567, 4'h0);
    chk("wrsel0_nowrite", 64'(wr_cnt), 64'(pre));
    run_check("rd4", PI1_OPREAD, 4, 32'h0, 4'h0);
    chk("rd4_const", 64'(pi1.pi1_data_o), 64'h00000000CAFEF00D);

    for (int i = 0; i < 120; i++) begin
      int r, a;
      logic [1:0] op;
      logic [3:0] s;
      r = $urandom_range(0, 16);
      a = (r == 16) ? SZ-1 : r;
      op = 2'($urandom_range(1, 3));
      case ($urandom_range(0, 3))
        0:       s = 4'hF;
        1:       s = 4'h0;
        default: s = 4'($urandom);
      endcase
      run_check("rand", op, a, $urandom, s);
    end

    for (int a = 0; a < 16; a++) run_check("sweep", PI1_OPREAD, a, 32'h0, 4'h0);
    run_check("sweep_top", PI1_OPREAD, SZ-1, 32'h0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
